spi_reg_slave: RTL
==================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Parameters
REQ-001 SHALL have parameters: WIDTH, default 8, data word width in bits (8, 16 or 32); ADDR_W, default 4, register address width (1..7); RESET_VAL, default 0, reset value of every register.
REQ-002 SHALL define DEPTH = 2**ADDR_W registers.

Interface
REQ-003 sclk  input  1  SPI clock; sole clock; MOSI sampled on rising edge, MISO launched on falling edge (SPI mode 0).
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cs_n  input  1  chip select, active low; high SHALL asynchronously reset frame state only.
REQ-006 mosi  input  1  serial data in, MSB first.
REQ-007 miso  output  1  serial data out, MSB first.
REQ-008 miso_oe  output  1  tristate enable; SHALL equal ~cs_n combinationally.
REQ-009 regs  output  DEPTH*WIDTH  flattened register file; register i at bits [i*WIDTH +: WIDTH].
REQ-010 wr_toggle  output  1  inverts once per committed write word; for fabric-side toggle synchroniser.
REQ-011 wr_addr  output  ADDR_W  address of most recent committed write.
REQ-012 frame_err  output  1  set on bad command; cleared at next frame's command completion if valid.

Function
REQ-013 Frame SHALL be: 8-bit command, then any number of WIDTH-bit data words until cs_n rises.
REQ-014 Command bit 7 = 1 read, 0 write; bits [6:0] = start address; bits [6:ADDR_W] nonzero SHALL be a bad command.
REQ-015 States: CMD (initial, after cs_n high), WDATA, RDATA, ERR.
REQ-016 CMD -> WDATA or RDATA on the rising edge sampling command bit 0 when valid; -> ERR when bad, setting frame_err.
REQ-017 ERR SHALL ignore mosi, drive miso 0 and hold until cs_n high.
REQ-018 Bit counter SHALL count 0..7 in CMD, 0..WIDTH-1 per data word, wrapping to 0 after each word.
REQ-019 WDATA: on the rising edge sampling a word's last bit, SHALL write the assembled word to regs[addr], set wr_addr = addr, invert wr_toggle, increment addr.
REQ-020 RDATA: on the falling edge after the last command bit, SHALL load the read shifter with regs[addr]; miso = shifter MSB; each later falling edge SHALL shift left, except the falling edge after a word's last bit, which SHALL load regs[addr] after increment.
REQ-021 Read data SHALL be captured at load time; writes in the same frame are impossible (read-only frame).
REQ-022 addr SHALL increment modulo DEPTH (DEPTH-1 wraps to 0) in both read and write bursts.
REQ-023 miso SHALL be 0 in CMD, ERR, and while cs_n high.
REQ-024 cs_n rising mid-word SHALL discard the partial word: no register write, no wr_toggle change; registers preserved.
REQ-025 Frame with zero or partial data words SHALL leave regs, wr_addr, wr_toggle unchanged.
REQ-026 cs_n deasserted then reasserted SHALL always start in CMD with bit counter 0, regardless of prior state.

Reset
REQ-027 rst SHALL asynchronously set: state CMD, bit counter 0, all regs RESET_VAL, read shifter 0, miso 0, wr_toggle 0, wr_addr 0, frame_err 0.
REQ-028 rst asserted mid-frame SHALL abort it; after release with cs_n still low, the frame SHALL resume from CMD at the next rising sclk (no recovery of the aborted frame).
REQ-029 rst SHALL take precedence over cs_n and sclk.

Verification (WIDTH=8, ADDR_W=4)
REQ-030 Write burst: cmd 0x03, data 0xA1 0xB2 -> regs[3]=0xA1, regs[4]=0xB2, wr_toggle toggles twice (ends 0), wr_addr=4.
REQ-031 Wrap: cmd 0x0F, data 0x11 0x22 -> regs[15]=0x11, regs[0]=0x22; then read cmd 0x8F, two words -> miso shifts 0x11 then 0x22.
REQ-032 Partial abort: cmd 0x05, 5 bits of data, cs_n high -> regs[5] unchanged, wr_toggle unchanged; next frame cmd 0x85 reads old value.
REQ-033 Bad command: cmd 0x20 (bit 5 set), data 0xFF -> frame_err=1, no register change, miso 0; next frame cmd 0x01 -> frame_err=0.
REQ-034 Reset mid-write: cmd 0x02, data 0x55 completed, rst pulse during second word -> all regs=RESET_VAL, wr_toggle=0, wr_addr=0, frame_err=0.
REQ-035 miso_oe follows ~cs_n in all scenarios; miso=0 throughout every command phase.

Source files
------------

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-file slave. A frame is an 8-bit command (R/W + start address)
// followed by auto-incrementing data words. cs_n high clears all frame state.
module spi_reg_slave #(
    parameter int               WIDTH     = 8,
    parameter int               ADDR_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         sclk,
    input  logic                         rst,
    input  logic                         cs_n,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe,
    output logic [(2**ADDR_W)*WIDTH-1:0] regs,
    output logic                         wr_toggle,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WIDTH-1);

    typedef enum logic [1:0] {S_CMD, S_WDATA, S_RDATA, S_ERR} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [6:0]        cmd_sh;
    logic [WIDTH-2:0]  wr_sh;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  rd_sh;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic [7:0]        cmd_word;
    logic [WIDTH-1:0]  wr_word;
    logic              cmd_bad, cmd_done, word_done;

    // The bit currently on mosi completes the command / data word on this rising edge.
    assign cmd_word  = {cmd_sh, mosi};
    assign wr_word   = {wr_sh, mosi};
    assign cmd_bad   = |(cmd_word[6:0] >> ADDR_W);
    assign cmd_done  = (state == S_CMD) && (bit_cnt == CMD_LAST);
    assign word_done = (state == S_WDATA || state == S_RDATA) && (bit_cnt == WORD_LAST);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        if (cmd_done)
            state_nx = cmd_bad ? S_ERR : (cmd_word[7] ? S_RDATA : S_WDATA);
    end

    always_ff @(posedge sclk or posedge rst or posedge cs_n) begin
        if (rst || cs_n) begin
            state   <= S_CMD;
            bit_cnt <= '0;
            cmd_sh  <= '0;
            wr_sh   <= '0;
            addr    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_CMD: begin
                    cmd_sh  <= {cmd_sh[5:0], mosi};
                    bit_cnt <= cmd_done ? '0 : bit_cnt + 1'b1;
                    if (cmd_done)
                        addr <= cmd_word[ADDR_W-1:0];
                end
                S_WDATA, S_RDATA: begin
                    bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
                    if (word_done)
                        addr <= addr + 1'b1;
                    if (state == S_WDATA)
                        wr_sh <= {wr_sh[WIDTH-3:0], mosi};
                end
                default: ;
            endcase
        end
    end

    // Register file and write-side status survive cs_n; only rst clears them.
    // NOTE: the register file is reset explicitly because every word has a defined reset value.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= RESET_VAL;
            wr_toggle <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (cmd_done)
                frame_err <= cmd_bad;
            if (state == S_WDATA && word_done) begin
                mem[addr] <= wr_word;
                wr_addr   <= addr;
                wr_toggle <= ~wr_toggle;
            end
        end
    end

    // Falling-edge read shifter: bit_cnt == 0 in RDATA means a fresh word is due.
    always_ff @(negedge sclk or posedge rst or posedge cs_n) begin
        if (rst || cs_n)
            rd_sh <= '0;
        else if (state == S_RDATA)
            rd_sh <= (bit_cnt == '0) ? mem[addr] : (rd_sh << 1);
    end

    assign miso    = rd_sh[WIDTH-1];
    assign miso_oe = ~cs_n;

    always_comb begin
        regs = '0;
        for (int i = 0; i < DEPTH; i++)
            regs[i*WIDTH +: WIDTH] = mem[i];
    end

endmodule
